// File: rtl/hazard_scoreboard.sv
// Purpose : interlock + forwarding unit; tracks in-flight register writers in a DEPTH-stage shift pipe.
// Latency : lookup is combinational on current stage contents; an issued writer is visible next cycle.
// Backpressure: raises stall when a matching producer is not yet forwardable; flush cancels the stall.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   issue_valid      instruction present in decode
//   issue_we         issuing instruction writes a register
//   issue_is_load    issuing instruction is a load
//   issue_rd         destination register of the issuing instruction
//   src_used         per-source "operand is read"
//   src_addr         source addresses, src i at [i*ADDR_W +: ADDR_W]
//   flush            squash the decode and stage-1 instructions
//   stall            hold decode/PC and insert a bubble
//   fwd_sel          per source: 0 = register file, k = result of the stage-k instruction
//   busy             any stage entry valid
module hazard_scoreboard #(
  parameter int ADDR_W           = 5,
  parameter int DEPTH            = 3,
  parameter int NUM_SRC          = 2,
  parameter int ALU_READY_STAGE  = 1,
  parameter int LOAD_READY_STAGE = 2,
  localparam int SEL_W           = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  input  logic                      issue_we,
  input  logic                      issue_is_load,
  input  logic [ADDR_W-1:0]         issue_rd,
  input  logic [NUM_SRC-1:0]        src_used,
  input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
  input  logic                      flush,
  output logic                      stall,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      busy
);

  // Stage entries; array index j holds pipeline stage j+1 (index 0 = EX).
  logic [DEPTH-1:0]  st_valid;
  logic [DEPTH-1:0]  st_we;
  logic [DEPTH-1:0]  st_load;
  logic [ADDR_W-1:0] st_rd [DEPTH];

  logic [NUM_SRC-1:0] src_stall;

  // Stage pipeline: always advances, stage DEPTH retires every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_valid <= '0;
      st_we    <= '0;
      st_load  <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        st_rd[j] <= '0;
      end
    end else begin
      // Stage-1 load mux is the only place stall feeds back into state.
      st_valid[0] <= issue_valid & ~stall & ~flush;
      st_we[0]    <= issue_we;
      st_load[0]  <= issue_is_load;
      st_rd[0]    <= issue_rd;
      for (int j = 1; j < DEPTH; j++) begin
        // The squashed stage-1 instruction moves on as a bubble.
        st_valid[j] <= st_valid[j-1] & ~((j == 1) & flush);
        st_we[j]    <= st_we[j-1];
        st_load[j]  <= st_load[j-1];
        st_rd[j]    <= st_rd[j-1];
      end
    end
  end

  // Per-source lookup. Stages are scanned oldest to youngest so the
  // youngest match overwrites any older one.
  always_comb begin
    fwd_sel   = '0;
    src_stall = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      logic [ADDR_W-1:0] a;
      logic [SEL_W-1:0]  sel;
      logic              req;
      a   = src_addr[i*ADDR_W +: ADDR_W];
      sel = '0;
      req = 1'b0;
      // r0 is hardwired, so it never needs forwarding or interlock.
      if (src_used[i] && (a != '0)) begin
        for (int k = DEPTH; k >= 1; k--) begin
          if (st_valid[k-1] && st_we[k-1] && (st_rd[k-1] == a)) begin
            if (k >= (st_load[k-1] ? LOAD_READY_STAGE : ALU_READY_STAGE)) begin
              sel = SEL_W'(k);
              req = 1'b0;
            end else begin
              sel = '0;
              req = 1'b1;
            end
          end
        end
      end
      fwd_sel[i*SEL_W +: SEL_W] = sel;
      src_stall[i]              = req;
    end
  end

  assign stall = issue_valid & ~flush & (|src_stall);
  assign busy  = |st_valid;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard: default configuration plus a
// DEPTH=5 / LOAD_READY_STAGE=4 / NUM_SRC=3 instance.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default instance
  logic       issue_valid, issue_we, issue_is_load, flush;
  logic [4:0] issue_rd;
  logic [1:0] src_used;
  logic [9:0] src_addr;
  logic       stall, busy;
  logic [3:0] fwd_sel;

  // Deep instance
  logic        issue_valid5, issue_we5, issue_is_load5, flush5;
  logic [4:0]  issue_rd5;
  logic [2:0]  src_used5;
  logic [14:0] src_addr5;
  logic        stall5, busy5;
  logic [8:0]  fwd_sel5;

  int n_checks = 0;
  int n_errors = 0;

  hazard_scoreboard u_dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_is_load(issue_is_load),
    .issue_rd(issue_rd), .src_used(src_used), .src_addr(src_addr), .flush(flush),
    .stall(stall), .fwd_sel(fwd_sel), .busy(busy)
  );

  hazard_scoreboard #(.DEPTH(5), .NUM_SRC(3), .LOAD_READY_STAGE(4)) u_dut5 (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid5), .issue_we(issue_we5), .issue_is_load(issue_is_load5),
    .issue_rd(issue_rd5), .src_used(src_used5), .src_addr(src_addr5), .flush(flush5),
    .stall(stall5), .fwd_sel(fwd_sel5), .busy(busy5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_iss(input logic v, input logic we, input logic ld, input logic [4:0] rd,
                         input logic [1:0] used, input logic [4:0] a0, input logic [4:0] a1);
    issue_valid   = v;
    issue_we      = we;
    issue_is_load = ld;
    issue_rd      = rd;
    src_used      = used;
    src_addr      = {a1, a0};
  endtask

  task automatic set_iss5(input logic v, input logic we, input logic ld, input logic [4:0] rd,
                          input logic [2:0] used, input logic [4:0] a2);
    issue_valid5   = v;
    issue_we5      = we;
    issue_is_load5 = ld;
    issue_rd5      = rd;
    src_used5      = used;
    src_addr5      = {a2, 10'd0};
  endtask

  initial begin
    rst    = 1'b1;
    flush  = 1'b0;
    flush5 = 1'b0;
    set_iss(0, 0, 0, 0, 2'b00, 0, 0);
    set_iss5(0, 0, 0, 0, 3'b000, 0);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    set_iss(1, 0, 0, 0, 2'b01, 5, 0);
    settle();
    check("reset_stall", stall, 0);
    check("reset_fwd", fwd_sel, 0);
    check("reset_busy", busy, 0);
    check("reset_busy5", busy5, 0);
    tick();

    // ALU chain on r3
    set_iss(1, 1, 0, 3, 2'b00, 0, 0);
    settle();
    check("alu_issue_stall", stall, 0);
    tick();
    set_iss(1, 0, 0, 0, 2'b01, 3, 0);
    settle();
    check("alu_fwd_s1", fwd_sel[1:0], 1);
    check("alu_stall_s1", stall, 0);
    check("alu_busy", busy, 1);
    tick();
    settle();
    check("alu_fwd_s2", fwd_sel[1:0], 2);
    tick();
    settle();
    check("alu_fwd_s3", fwd_sel[1:0], 3);
    tick();
    settle();
    check("alu_fwd_retired", fwd_sel[1:0], 0);
    tick();

    // Load-use on r4 via src1
    set_iss(1, 1, 1, 4, 2'b00, 0, 0);
    tick();
    set_iss(1, 0, 0, 0, 2'b10, 0, 4);
    settle();
    check("lu_stall", stall, 1);
    check("lu_fwd_stalled", fwd_sel[3:2], 0);
    tick();
    settle();
    check("lu_stall_released", stall, 0);
    check("lu_fwd", fwd_sel[3:2], 2);
    tick();

    // Drain, busy returns low
    set_iss(0, 0, 0, 0, 2'b00, 0, 0);
    tick();
    tick();
    tick();
    settle();
    check("drain_busy", busy, 0);

    // Youngest wins: stage1 r7, stage2 r0, stage3 r7
    set_iss(1, 1, 0, 7, 2'b00, 0, 0);
    tick();
    set_iss(1, 1, 0, 0, 2'b00, 0, 0);
    tick();
    set_iss(1, 1, 0, 7, 2'b00, 0, 0);
    tick();
    set_iss(1, 0, 0, 0, 2'b01, 7, 7);
    settle();
    check("young_fwd_unused_src1", fwd_sel, 4'b0001);
    check("young_stall", stall, 0);
    set_iss(1, 0, 0, 0, 2'b11, 0, 0);
    settle();
    check("r0_fwd", fwd_sel, 0);
    check("r0_stall", stall, 0);
    set_iss(0, 0, 0, 0, 2'b00, 0, 0);
    tick();
    tick();
    tick();

    // Flush during a load-use stall
    set_iss(1, 1, 1, 4, 2'b00, 0, 0);
    tick();
    set_iss(1, 0, 0, 0, 2'b01, 4, 0);
    settle();
    check("fl_stall_before", stall, 1);
    issue_valid = 1'b0;
    settle();
    check("fl_stall_novalid", stall, 0);
    issue_valid = 1'b1;
    flush = 1'b1;
    settle();
    check("fl_stall_flushed", stall, 0);
    tick();
    flush = 1'b0;
    settle();
    check("fl_fwd_after", fwd_sel, 0);
    check("fl_stall_after", stall, 0);
    set_iss(0, 0, 0, 0, 2'b00, 0, 0);

    // Deep instance: load r9, consumer on src2
    set_iss5(1, 1, 1, 9, 3'b000, 0);
    tick();
    set_iss5(1, 0, 0, 0, 3'b100, 9);
    settle();
    check("d5_stall_c1", stall5, 1);
    tick();
    settle();
    check("d5_stall_c2", stall5, 1);
    tick();
    settle();
    check("d5_stall_c3", stall5, 1);
    tick();
    settle();
    check("d5_stall_done", stall5, 0);
    check("d5_fwd", fwd_sel5, {3'd4, 6'd0});
    set_iss5(0, 0, 0, 0, 3'b000, 0);
    for (int n = 0; n < 5; n++) tick();

    // Deep instance: reset in the middle of the stall
    set_iss5(1, 1, 1, 9, 3'b000, 0);
    tick();
    set_iss5(1, 0, 0, 0, 3'b100, 9);
    settle();
    check("d5r_stall_c1", stall5, 1);
    tick();
    settle();
    check("d5r_stall_c2", stall5, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    check("d5r_stall_after_rst", stall5, 0);
    check("d5r_fwd_after_rst", fwd_sel5, 0);
    check("d5r_busy_after_rst", busy5, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
